// File: rtl/vjtag_readback.sv
// Readback transmitter for the virtual JTAG link: tck-domain byte FIFO
// scanned out as a framed word, popped only after a complete valid scan.
module vjtag_readback #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              tck,
    input  logic              aclr_n,
    input  logic              tdi,
    input  logic              ir_in,
    input  logic              v_cdr,
    input  logic              v_sdr,
    input  logic              udr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [AW:0]       fifo_level,
    output logic              overflow,
    output logic              tdo
);

    localparam int FW = DATA_W + AW + 2;
    localparam int CW = $clog2(FW + 1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(FW);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURED,
        SHIFT,
        COMPLETE
    } state_t;

    state_t state, state_n;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic [FW-1:0]     shift, frame;
    logic [DATA_W-1:0] head;
    logic [CW-1:0]     cnt, cnt_n;
    logic              bypass, cap_valid, udr_q;
    logic              full, empty, push, pop, load;
    logic              udr_rise, shift_en;

    assign fifo_level = wr_ptr - rd_ptr;
    assign full       = (fifo_level == LVL_FULL);
    assign empty      = (wr_ptr == rd_ptr);
    assign wr_ready   = !full;
    assign push       = wr_valid && !full;
    assign udr_rise   = udr && !udr_q;
    assign shift_en   = v_sdr && ir_in;
    assign head       = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign frame      = {fifo_level, head, !empty};
    assign tdo        = ir_in ? shift[0] : bypass;

    always_ff @(posedge tck) begin
        if (!aclr_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Capture outranks update so a rescan always restarts cleanly.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        pop     = 1'b0;
        if (!ir_in) begin
            state_n = IDLE;
        end else if (v_cdr) begin
            state_n = CAPTURED;
            cnt_n   = '0;
            load    = 1'b1;
        end else if (udr_rise) begin
            pop     = (state == COMPLETE) && cap_valid;
            state_n = IDLE;
        end else if (v_sdr && (state == CAPTURED || state == SHIFT)) begin
            cnt_n   = cnt + 1'b1;
            state_n = (cnt_n == CNT_MAX) ? COMPLETE : SHIFT;
        end
    end

    always_ff @(posedge tck) begin
        if (!aclr_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            shift     <= '0;
            bypass    <= 1'b0;
            cnt       <= '0;
            overflow  <= 1'b0;
            udr_q     <= 1'b0;
            cap_valid <= 1'b0;
        end else begin
            udr_q  <= udr;
            bypass <= tdi;
            cnt    <= cnt_n;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_valid && full) begin
                overflow <= 1'b1;
            end
            if (load) begin
                shift     <= frame;
                cap_valid <= !empty;
            end else if (shift_en) begin
                shift <= {tdi, shift[FW-1:1]};
            end
        end
    end

    always_ff @(posedge tck) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_vjtag_readback.sv
// Directed bench for vjtag_readback: scans frames out bit by bit and
// compares them against hand-built frames.
module tb_vjtag_readback;

    logic       tck = 1'b0;
    logic       aclr_n = 1'b0;
    logic       tdi = 1'b0;
    logic       ir_in = 1'b0;
    logic       v_cdr = 1'b0;
    logic       v_sdr = 1'b0;
    logic       udr = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [4:0] fifo_level;
    logic       overflow;
    logic       tdo;

    int n_cmp = 0;
    int n_bad = 0;

    logic [13:0] got;

    vjtag_readback dut (
        .tck        (tck),
        .aclr_n     (aclr_n),
        .tdi        (tdi),
        .ir_in      (ir_in),
        .v_cdr      (v_cdr),
        .v_sdr      (v_sdr),
        .udr        (udr),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .tdo        (tdo)
    );

    always #5 tck = ~tck;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] frm(input logic [4:0] lvl,
                                        input logic [7:0] b,
                                        input logic v);
        return {lvl, b, v};
    endfunction

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_data  = b;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic scan(input int n, output logic [13:0] bits);
        bits  = '0;
        ir_in = 1'b1;
        v_cdr = 1'b1;
        tick();
        v_cdr = 1'b0;
        for (int k = 0; k < n; k++) begin
            bits[k] = tdo;
            v_sdr   = 1'b1;
            tick();
        end
        v_sdr = 1'b0;
    endtask

    task automatic update();
        udr = 1'b1;
        tick();
        udr = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] pat;

        ir_in = 1'b1;
        tick();
        tick();
        chk("rst_ready", 32'(wr_ready), 32'd1);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_tdo", 32'(tdo), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        aclr_n = 1'b1;
        tick();

        // basic read
        push(8'hA5);
        chk("basic_level", 32'(fifo_level), 32'd1);
        scan(14, got);
        chk("basic_frame", 32'(got), 32'(frm(5'd1, 8'hA5, 1'b1)));
        update();
        chk("basic_pop", 32'(fifo_level), 32'd0);

        // partial scan, then rescan returns the same head
        push(8'h3C);
        scan(6, got);
        chk("part_bits", 32'(got & 14'h3F),
            32'(frm(5'd1, 8'h3C, 1'b1) & 14'h3F));
        update();
        chk("part_nopop", 32'(fifo_level), 32'd1);
        scan(14, got);
        chk("part_rescan", 32'(got), 32'(frm(5'd1, 8'h3C, 1'b1)));
        update();
        chk("part_pop", 32'(fifo_level), 32'd0);

        // full FIFO and overflow
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
        end
        chk("full_ready", 32'(wr_ready), 32'd0);
        chk("full_level", 32'(fifo_level), 32'd16);
        chk("full_ovf0", 32'(overflow), 32'd0);
        push(8'h10);
        chk("full_ovf1", 32'(overflow), 32'd1);
        chk("full_level2", 32'(fifo_level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            scan(14, got);
            chk("full_frame", 32'(got),
                32'(frm(5'(16 - i), 8'(i), 1'b1)));
            update();
        end
        chk("full_drain", 32'(fifo_level), 32'd0);
        chk("full_ovf_sticky", 32'(overflow), 32'd1);

        // push lands on the udr-rising edge
        push(8'h11);
        push(8'h22);
        push(8'h33);
        scan(14, got);
        chk("sim_frame", 32'(got), 32'(frm(5'd3, 8'h11, 1'b1)));
        udr      = 1'b1;
        wr_data  = 8'h44;
        wr_valid = 1'b1;
        tick();
        udr      = 1'b0;
        wr_valid = 1'b0;
        tick();
        chk("sim_level", 32'(fifo_level), 32'd3);
        scan(14, got);
        chk("sim_b22", 32'(got), 32'(frm(5'd3, 8'h22, 1'b1)));
        update();
        scan(14, got);
        chk("sim_b33", 32'(got), 32'(frm(5'd2, 8'h33, 1'b1)));
        update();
        scan(14, got);
        chk("sim_b44", 32'(got), 32'(frm(5'd1, 8'h44, 1'b1)));
        update();
        chk("sim_empty", 32'(fifo_level), 32'd0);

        // udr held high pops once
        push(8'h55);
        push(8'h66);
        scan(14, got);
        udr = 1'b1;
        tick();
        tick();
        tick();
        udr = 1'b0;
        tick();
        chk("hold_level", 32'(fifo_level), 32'd1);
        scan(14, got);
        chk("hold_frame", 32'(got), 32'(frm(5'd1, 8'h66, 1'b1)));
        update();

        // empty scan returns zero and pops nothing
        scan(14, got);
        chk("empty_frame", 32'(got), 32'd0);
        update();
        chk("empty_level", 32'(fifo_level), 32'd0);
        chk("empty_ready", 32'(wr_ready), 32'd1);

        // bypass: tdo is tdi delayed one tck
        ir_in = 1'b0;
        pat   = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            tdi = pat[i];
            tick();
            chk("bypass", 32'(tdo), 32'(pat[i]));
        end
        tdi = 1'b0;
        tick();

        // reset mid-scan
        push(8'h5A);
        ir_in = 1'b1;
        v_cdr = 1'b1;
        tick();
        v_cdr = 1'b0;
        v_sdr = 1'b1;
        tick();
        tick();
        tick();
        v_sdr  = 1'b0;
        aclr_n = 1'b0;
        tick();
        aclr_n = 1'b1;
        chk("mid_level", 32'(fifo_level), 32'd0);
        chk("mid_ready", 32'(wr_ready), 32'd1);
        chk("mid_ovf", 32'(overflow), 32'd0);
        chk("mid_tdo", 32'(tdo), 32'd0);
        update();
        chk("mid_nopop", 32'(fifo_level), 32'd0);
        scan(14, got);
        chk("mid_frame", 32'(got), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vjtag_readback.md
# vjtag_readback

Host-readback transmitter for the virtual JTAG link: the opposite direction to the host-to-FPGA LED/data register path. FPGA-side logic pushes bytes into a small FIFO in the `tck` domain. On each scan of the readback instruction, the block captures a framed word (occupancy, head byte, valid flag) and shifts it out on `tdo`. The head byte is popped only after a complete, valid frame has been scanned and the update pulse arrives, so an aborted or partial scan never loses data.

## Interface
- `DATA_W`, default 8: payload width in bits.
- `DEPTH`, default 16: FIFO depth in words; must be a power of two, at least 2.
- `AW`, default 4: log2(`DEPTH`).
- `FW`, derived, default 14: frame width, equal to `DATA_W + AW + 2`. Not overridable.
- `tck` input, 1 bit: JTAG clock; the only clock.
- `aclr_n` input, 1 bit: reset, synchronous to `tck`, active-low.
- `tdi` input, 1 bit: serial data from the host.
- `ir_in` input, 1 bit: 1 selects the readback DR; 0 selects the 1-bit bypass register.
- `v_cdr` input, 1 bit: virtual Capture-DR state.
- `v_sdr` input, 1 bit: virtual Shift-DR state.
- `udr` input, 1 bit: virtual Update-DR state; the block acts on its rising edge, sampled on `tck`.
- `wr_data` input, `DATA_W` bits: byte to enqueue.
- `wr_valid` input, 1 bit: enqueue request.
- `wr_ready` output, 1 bit: FIFO not full.
- `fifo_level` output, `AW+1` bits: current occupancy, 0 to `DEPTH`.
- `overflow` output, 1 bit: sticky flag, set when a push is dropped.
- `tdo` output, 1 bit: serial data to the host.

## Operation
- **Frame layout:** the frame is shifted out LSB first.
  - Bit 0: valid, equal to !empty.
  - Bits `DATA_W:1`: head byte; all zeros when the FIFO is empty.
  - Bits `FW-1:DATA_W+1`: `fifo_level` as it stood at capture.
- **FIFO:** circular buffer with write and read pointers of `AW+1` bits each.
  - Push happens when `wr_valid && wr_ready`.
  - `wr_valid` while full drops the byte and sets `overflow`. This holds even if a pop occurs on the same edge.
  - `overflow` clears only on reset.
- **Shift register:** `FW` bits.
  - On capture, the frame is loaded.
  - On each `v_sdr && ir_in` edge, it shifts right with `tdi` entering at the MSB.
- **Bypass register:** loads `tdi` on every edge.
- **`tdo`:** combinational; `shift[0]` when `ir_in` = 1, otherwise the bypass register.
- **State machine (`tck`):**
  - IDLE → CAPTURED on `v_cdr && ir_in`: load the frame and clear the bit counter.
  - CAPTURED or SHIFT → SHIFT on `v_sdr && ir_in`: the counter increments and saturates at `FW`.
  - SHIFT → COMPLETE when the counter reaches `FW`. Shifting may continue; the counter stays saturated.
  - Any state, on `v_cdr && ir_in`: reload the frame and restart in CAPTURED, so a rescan repeats the same head byte.
  - Any state, on `udr` rising: pop one word if the state is COMPLETE and the captured valid bit is 1; then go to IDLE.
  - Any state other than IDLE, when `ir_in` = 0: go to IDLE with no pop.
- **Simultaneous push and pop:** both are performed and `fifo_level` is unchanged.
- **Capture and push on the same edge:** the frame reflects the pre-edge FIFO contents.

## Timing
- **Reset** (`aclr_n` low at a `tck` edge):
  - Pointers, shift register, bypass register, counter, `overflow` and the `udr` edge detector are all 0.
  - State is IDLE.
  - Outputs: `wr_ready` = 1, `fifo_level` = 0, `tdo` = 0.
- **Reset mid-scan:** the scan is abandoned and the FIFO contents are lost.
- **Push latency:** `fifo_level` and `wr_ready` update on the edge that accepts the push.
- **Capture to first bit:** `tdo` shows frame bit 0 immediately after the capture edge; bit k appears after k shift edges.
- **Pop latency:** the read pointer advances on the edge that samples `udr` going from 0 to 1; `fifo_level` drops on that edge.
- **`udr` held high:** counts as one event; a new event requires `udr` to be sampled at 0 first.
- **Empty FIFO:** a complete scan returns valid = 0 and pops nothing; pointers wrap modulo `2*DEPTH`.

## Test plan
- **Basic read:** reset, push 0xA5, scan the full 14 bits → `tdo` sequence LSB first is 1, 0xA5 LSB first, then level 1; after `udr`, `fifo_level` = 0.
- **Partial scan:** push 0x3C, scan only 6 bits, then `udr` → no pop; a full rescan returns 0x3C.
- **Full FIFO:** push 17 bytes 0x00..0x10 → `wr_ready` = 0 after 16 pushes; 0x10 is dropped and `overflow` = 1; 16 complete scans return 0x00..0x0F in order with level 16 down to 1.
- **Simultaneous push and pop:** with level 3, a push lands on the `udr`-rising edge → level stays 3 and the order of the remaining bytes is preserved.
- **Empty and bypass:** scan with an empty FIFO → frame equals 0 and no pop. With `ir_in` = 0, `tdo` equals `tdi` delayed by one `tck`.
- **Reset mid-scan:** assert `aclr_n` low during SHIFT → all outputs at reset values and state IDLE.
